ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Shares the single-port synchronous system RAM between the 65xx CPU and a DMA requester.
//  The CPU has priority. DMA gets idle slots immediately; when the CPU is saturating RAM, DMA is
//  forced in after a bounded wait. Forced cycles stall the CPU through RDY.
//  Sits between CPU bus / RAM decode and the ram_mem array; owns ram_addr/we/wdata and cpu_rdy.
// PARAMETERS
//  AW          16  address width (20 in bank-switching builds)
//  STARVE_MAX  4   consecutive denied DMA cycles before DMA is forced onto RAM (>=1)
//  BURST_MAX   8   max DMA cycles per forced burst before returning to CPU (>=1)
// PORTS
//  clk         in   1   system clock
//  reset       in   1   asynchronous, active-high reset
//  cpu_ab      in   AW  CPU address
//  cpu_do      in   8   CPU write data
//  cpu_we_n    in   1   CPU write enable, low-true
//  cpu_sel     in   1   CPU access targets RAM this cycle (pRam decode)
//  cpu_rdy     out  1   CPU ready; 0 freezes CPU, which holds ab/do/we_n and repeats the access
//  cpu_di      out  8   RAM read data for CPU (replaces direct ram_do in the data mux)
//  dma_req     in   1   DMA access request; held with addr/data until dma_gnt
//  dma_we      in   1   DMA write (1) / read (0)
//  dma_addr    in   AW  DMA address
//  dma_wdata   in   8   DMA write data
//  dma_gnt     out  1   DMA access performed this cycle (combinational)
//  dma_rvalid  out  1   registered; dma_rdata valid, one cycle after a granted DMA read
//  dma_rdata   out  8   DMA read data
//  ram_addr    out  AW  RAM address (combinational mux)
//  ram_we      out  1   RAM write strobe, high-true
//  ram_wdata   out  8   RAM write data
//  ram_rdata   in   8   RAM registered read data (1-cycle latency)
// BEHAVIOUR
//  States: S_CPU (default), S_DMA (forced burst). Registered: state, starve_cnt, burst_cnt,
//   owner_q (CPU/DMA/NONE owner of previous cycle), dma_rvalid, cpu_di_hold.
//  Reset: state=S_CPU, counters=0, owner_q=NONE, dma_rvalid=0, cpu_di_hold=8'h00.
//   => cpu_rdy=1, dma_gnt=0, ram_we=0.
//  Slot owner per cycle (combinational):
//   S_CPU: DMA if dma_req & ~cpu_sel; else CPU if cpu_sel; else NONE.
//   S_DMA: DMA if dma_req; else CPU if cpu_sel; else NONE.
//  cpu_rdy = ~(cpu_sel & owner==DMA). dma_gnt = (owner==DMA).
//  RAM mux: owner DMA -> dma_addr/dma_we/dma_wdata; CPU -> cpu_ab/~cpu_we_n/cpu_do.
//   NONE -> cpu_ab, ram_we=0.
//  starve_cnt (S_CPU only): +1 when dma_req & cpu_sel; cleared on any dma_gnt or ~dma_req.
//   Saturates at STARVE_MAX.
//  S_CPU->S_DMA when starve_cnt==STARVE_MAX-1 and this cycle increments it; burst_cnt<=0.
//   The first forced cycle is the next cycle; the latency from first denial is STARVE_MAX cycles.
//  S_DMA: burst_cnt +1 per dma_gnt. ->S_CPU, starve_cnt<=0 when ~dma_req, or when a grant makes
//   burst_cnt==BURST_MAX. The CPU then gets >=1 cycle before DMA can be forced again.
//  Read return: owner_q<=owner. cpu_di = (owner_q==CPU) ? ram_rdata : cpu_di_hold.
//   cpu_di_hold<=ram_rdata when owner_q==CPU. A stalled CPU therefore sees its last serviced
//   read data.
//  dma_rvalid<=dma_gnt&~dma_we; dma_rdata=ram_rdata (valid only while dma_rvalid).
//  Simultaneous CPU write + DMA request with starve not expired: CPU write wins, DMA waits.
//  Reset asserted mid-burst: burst aborted, no ram_we during reset, pending DMA re-requests.
//  cpu_sel=0 with dma_req=1 every cycle: DMA granted every cycle; S_DMA never entered.
// STRUCTURE
//  Shared include ram_arbiter_defs.vh: state encodings S_CPU/S_DMA, owner codes
//   OWN_NONE/OWN_CPU/OWN_DMA.
//  Single module; no sub-module needed (counters and FSM are <150 lines).
// TESTING
//  1 CPU write 8'hA5 @0x0200 then read, dma_req=0 -> ram_we 1 cycle.
//    cpu_di=8'hA5 the cycle after the read; cpu_rdy=1 throughout.
//  2 cpu_sel=0, DMA read @0x0300 (holds 8'h3C) -> dma_gnt same cycle.
//    dma_rvalid=1, dma_rdata=8'h3C next cycle; cpu_rdy=1.
//  3 cpu_sel=1 continuous, dma_req=1 continuous, STARVE_MAX=4, BURST_MAX=8 -> 4 denied cycles.
//    Then 8 dma_gnt with cpu_rdy=0; then >=1 CPU cycle; then pattern repeats.
//  4 CPU read @0x0010 (8'h77) serviced, next cycle forced DMA read of 8'h11.
//    -> cpu_di stays 8'h77 while stalled; dma_rdata=8'h11 with dma_rvalid.
//  5 In S_DMA, dma_req drops after 3 grants -> state S_CPU next cycle; cpu_rdy=1; starve_cnt=0.
//  6 reset pulse mid-burst (async, between edges) -> immediately cpu_rdy=1, dma_gnt=0.
//    ram_we=0; dma_rvalid=0; S_CPU after release.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the CPU/DMA system-RAM arbiter: FSM states, slot-owner codes
// and counter-width helper.
package ram_arbiter_pkg;

   localparam int unsigned DW = 8;

   typedef enum logic {
      S_CPU = 1'b0,
      S_DMA = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_t;

   // Bits needed to hold a count in the range 0..max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/ram_arbiter_ctrl.sv
// Slot-ownership FSM: CPU has priority, DMA takes idle slots and is forced in
// for a bounded burst once it has been denied STARVE_MAX consecutive cycles.
module ram_arbiter_ctrl
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned BURST_MAX  = 8
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   cpu_sel,
   input  logic   dma_req,
   output owner_t owner_c
);

   localparam int unsigned SW = cnt_width(STARVE_MAX);
   localparam int unsigned BW = cnt_width(BURST_MAX);
   localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);
   localparam logic [SW-1:0] STARVE_TOP  = SW'(STARVE_MAX);
   localparam logic [BW-1:0] BURST_LAST  = BW'(BURST_MAX - 1);

   state_t          state_q, state_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic [BW-1:0]   burst_q, burst_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_CPU;
         starve_q <= '0;
         burst_q  <= '0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         burst_q  <= burst_d;
      end
   end

   // Owner is forced to NONE while reset is held so nothing touches RAM.
   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      burst_d  = burst_q;
      owner_c  = OWN_NONE;

      if (!reset) begin
         case (state_q)
            S_CPU: begin
               if (dma_req && !cpu_sel) begin
                  owner_c = OWN_DMA;
               end else if (cpu_sel) begin
                  owner_c = OWN_CPU;
               end

               if (owner_c == OWN_DMA || !dma_req) begin
                  starve_d = '0;
               end else if (cpu_sel) begin
                  if (starve_q == STARVE_LAST) begin
                     state_d = S_DMA;
                     burst_d = '0;
                  end
                  if (starve_q != STARVE_TOP) begin
                     starve_d = SW'(starve_q + 1'b1);
                  end
               end
            end

            S_DMA: begin
               if (dma_req) begin
                  owner_c = OWN_DMA;
               end else if (cpu_sel) begin
                  owner_c = OWN_CPU;
               end

               if (!dma_req) begin
                  state_d  = S_CPU;
                  starve_d = '0;
               end else begin
                  burst_d = BW'(burst_q + 1'b1);
                  if (burst_q == BURST_LAST) begin
                     state_d  = S_CPU;
                     starve_d = '0;
                  end
               end
            end

            default: begin
               state_d = S_CPU;
            end
         endcase
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-port system RAM between the 65xx CPU and a DMA requester;
// owns the RAM address/write mux, CPU RDY and the read-data return paths.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int unsigned AW         = 16,
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned BURST_MAX  = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] cpu_ab,
   input  logic [DW-1:0] cpu_do,
   input  logic          cpu_we_n,
   input  logic          cpu_sel,
   output logic          cpu_rdy,
   output logic [DW-1:0] cpu_di,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_gnt,
   output logic          dma_rvalid,
   output logic [DW-1:0] dma_rdata,
   output logic [AW-1:0] ram_addr,
   output logic          ram_we,
   output logic [DW-1:0] ram_wdata,
   input  logic [DW-1:0] ram_rdata
);

   owner_t        owner_c;
   owner_t        owner_q;
   logic [DW-1:0] cpu_di_hold;

   ram_arbiter_ctrl #(
      .STARVE_MAX (STARVE_MAX),
      .BURST_MAX  (BURST_MAX)
   ) u_ctrl (
      .clk     (clk),
      .reset   (reset),
      .cpu_sel (cpu_sel),
      .dma_req (dma_req),
      .owner_c (owner_c)
   );

   // RAM port mux; an unowned slot presents the CPU address with no write.
   always_comb begin
      ram_addr  = cpu_ab;
      ram_we    = 1'b0;
      ram_wdata = cpu_do;
      case (owner_c)
         OWN_DMA: begin
            ram_addr  = dma_addr;
            ram_we    = dma_we;
            ram_wdata = dma_wdata;
         end
         OWN_CPU: begin
            ram_we = ~cpu_we_n;
         end
         default: ;
      endcase
   end

   assign dma_gnt = (owner_c == OWN_DMA);
   assign cpu_rdy = ~(cpu_sel & (owner_c == OWN_DMA));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner_q     <= OWN_NONE;
         dma_rvalid  <= 1'b0;
         cpu_di_hold <= '0;
      end else begin
         owner_q    <= owner_c;
         dma_rvalid <= dma_gnt & ~dma_we;
         if (owner_q == OWN_CPU) begin
            cpu_di_hold <= ram_rdata;
         end
      end
   end

   // A stalled CPU keeps seeing the data of its last serviced access.
   assign cpu_di    = (owner_q == OWN_CPU) ? ram_rdata : cpu_di_hold;
   assign dma_rdata = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, hand sequences for
// the forced-burst corners, and random traffic against a behavioural model.
module tb_ram_arbiter;

   localparam int unsigned AW         = 16;
   localparam int unsigned STARVE_MAX = 4;
   localparam int unsigned BURST_MAX  = 8;
   localparam int O_NONE = 0;
   localparam int O_CPU  = 1;
   localparam int O_DMA  = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] cpu_ab;
   logic [7:0]    cpu_do;
   logic          cpu_we_n;
   logic          cpu_sel;
   logic          cpu_rdy;
   logic [7:0]    cpu_di;
   logic          dma_req;
   logic          dma_we;
   logic [AW-1:0] dma_addr;
   logic [7:0]    dma_wdata;
   logic          dma_gnt;
   logic          dma_rvalid;
   logic [7:0]    dma_rdata;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [7:0]    ram_wdata;
   logic [7:0]    ram_rdata;

   always #5 clk = ~clk;

   ram_arbiter #(
      .AW         (AW),
      .STARVE_MAX (STARVE_MAX),
      .BURST_MAX  (BURST_MAX)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_ab     (cpu_ab),
      .cpu_do     (cpu_do),
      .cpu_we_n   (cpu_we_n),
      .cpu_sel    (cpu_sel),
      .cpu_rdy    (cpu_rdy),
      .cpu_di     (cpu_di),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_gnt    (dma_gnt),
      .dma_rvalid (dma_rvalid),
      .dma_rdata  (dma_rdata),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   // Synchronous single-port RAM, read-before-write, 1-cycle read latency.
   logic [7:0] ram     [0:65535];
   logic [7:0] ref_mem [0:65535];

   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
   end

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chkv(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: consecutive-denial count, forced-burst length, and the
   // data each read returns one cycle later.
   bit         m_forced;
   int         m_denied;
   int         m_burst;
   int         m_prev_owner;
   bit         m_prev_dread;
   logic [7:0] m_hold;
   logic [7:0] m_prev_rdata;
   logic       prev_rdy;
   logic       prev_gnt;

   task automatic model_reset();
      m_forced     = 1'b0;
      m_denied     = 0;
      m_burst      = 0;
      m_prev_owner = O_NONE;
      m_prev_dread = 1'b0;
      m_hold       = 8'h00;
      m_prev_rdata = 8'h00;
   endtask

   task automatic model_cycle();
      int            own;
      logic [AW-1:0] a;
      logic          we;
      logic [7:0]    wd;
      if (reset) begin
         chk1("rst_rdy", cpu_rdy, 1'b1);
         chk1("rst_gnt", dma_gnt, 1'b0);
         chk1("rst_we", ram_we, 1'b0);
         chk1("rst_rvalid", dma_rvalid, 1'b0);
         chkv("rst_cpu_di", 16'(cpu_di), 16'h0000);
         model_reset();
         return;
      end
      if (dma_req && (m_forced || !cpu_sel)) own = O_DMA;
      else if (cpu_sel)                      own = O_CPU;
      else                                   own = O_NONE;
      a  = (own == O_DMA) ? dma_addr : cpu_ab;
      we = (own == O_DMA) ? dma_we : ((own == O_CPU) ? !cpu_we_n : 1'b0);
      wd = (own == O_DMA) ? dma_wdata : cpu_do;

      chk1("m_rdy", cpu_rdy, !(cpu_sel && own == O_DMA));
      chk1("m_gnt", dma_gnt, own == O_DMA);
      chk1("m_we", ram_we, we);
      chkv("m_addr", ram_addr, a);
      if (we) chkv("m_wdata", 16'(ram_wdata), 16'(wd));
      chkv("m_cpu_di", 16'(cpu_di), 16'((m_prev_owner == O_CPU) ? m_prev_rdata : m_hold));
      chk1("m_rvalid", dma_rvalid, m_prev_dread);
      if (m_prev_dread) chkv("m_dma_rdata", 16'(dma_rdata), 16'(m_prev_rdata));

      if (m_prev_owner == O_CPU) m_hold = m_prev_rdata;
      m_prev_rdata = ref_mem[a];
      if (we) ref_mem[a] = wd;
      m_prev_owner = own;
      m_prev_dread = (own == O_DMA) && !dma_we;

      if (!m_forced) begin
         if (own == O_DMA || !dma_req) m_denied = 0;
         else if (cpu_sel) begin
            m_denied++;
            if (m_denied == STARVE_MAX) begin
               m_forced = 1'b1;
               m_burst  = 0;
            end
         end
      end else if (!dma_req) begin
         m_forced = 1'b0;
         m_denied = 0;
      end else begin
         m_burst++;
         if (m_burst == BURST_MAX) begin
            m_forced = 1'b0;
            m_denied = 0;
         end
      end
   endtask

   task automatic advance();
      prev_rdy = cpu_rdy;
      prev_gnt = dma_gnt;
      model_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cpu(input logic sel, input logic we_n, input logic [15:0] ab, input logic [7:0] d);
      cpu_sel = sel; cpu_we_n = we_n; cpu_ab = ab; cpu_do = d;
   endtask

   task automatic set_dma(input logic req, input logic we, input logic [15:0] ad, input logic [7:0] d);
      dma_req = req; dma_we = we; dma_addr = ad; dma_wdata = d;
   endtask

   task automatic idle();
      set_cpu(1'b0, 1'b1, 16'h0000, 8'h00);
      set_dma(1'b0, 1'b0, 16'h0000, 8'h00);
   endtask

   typedef struct {
      logic        sel;
      logic        we_n;
      logic [15:0] ab;
      logic [7:0]  dout;
      logic        req;
      logic        dwe;
      logic [15:0] daddr;
      logic [7:0]  dwd;
      logic        e_rdy;
      logic        e_gnt;
      logic        e_we;
      logic        c_di;
      logic [7:0]  e_di;
      logic        c_rv;
      logic [7:0]  e_rd;
   } vec_t;

   vec_t tbl [8];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] v;
      reset = 1'b1;
      idle();
      prev_rdy = 1'b1;
      prev_gnt = 1'b1;
      for (int k = 0; k < 65536; k++) begin
         v = 8'($urandom);
         ram[k] = v;
         ref_mem[k] = v;
      end
      ram[16'h0300] = 8'h3C; ref_mem[16'h0300] = 8'h3C;
      ram[16'h0010] = 8'h77; ref_mem[16'h0010] = 8'h77;
      ram[16'h0400] = 8'h11; ref_mem[16'h0400] = 8'h11;
      model_reset();

      //              sel  we_n ab       do    req  dwe  daddr    dwd   rdy  gnt  we   c_di e_di  c_rv e_rd
      tbl[0] = '{1'b1, 1'b0, 16'h0200, 8'hA5, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
      tbl[1] = '{1'b1, 1'b1, 16'h0200, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
      tbl[2] = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00};
      tbl[3] = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0300, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};
      tbl[4] = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h3C};
      tbl[5] = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0301, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
      tbl[6] = '{1'b1, 1'b0, 16'h0302, 8'hC3, 1'b1, 1'b1, 16'h0303, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
      tbl[7] = '{1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00};

      repeat (2) @(posedge clk);
      #1;
      chk1("reset_rdy", cpu_rdy, 1'b1);
      chk1("reset_gnt", dma_gnt, 1'b0);
      chk1("reset_we", ram_we, 1'b0);
      chk1("reset_rvalid", dma_rvalid, 1'b0);
      chkv("reset_cpu_di", 16'(cpu_di), 16'h0000);
      reset = 1'b0;

      // Directed vector table
      for (int i = 0; i < 8; i++) begin
         set_cpu(tbl[i].sel, tbl[i].we_n, tbl[i].ab, tbl[i].dout);
         set_dma(tbl[i].req, tbl[i].dwe, tbl[i].daddr, tbl[i].dwd);
         @(negedge clk);
         chk1("tbl_rdy", cpu_rdy, tbl[i].e_rdy);
         chk1("tbl_gnt", dma_gnt, tbl[i].e_gnt);
         chk1("tbl_we", ram_we, tbl[i].e_we);
         if (tbl[i].c_di) chkv("tbl_cpu_di", 16'(cpu_di), 16'(tbl[i].e_di));
         if (tbl[i].c_rv) begin
            chk1("tbl_rvalid", dma_rvalid, 1'b1);
            chkv("tbl_dma_rdata", 16'(dma_rdata), 16'(tbl[i].e_rd));
         end
         advance();
      end

      // Saturated CPU + continuous DMA: 4 denials then 8 forced grants, repeating
      set_cpu(1'b1, 1'b1, 16'h0040, 8'h00);
      set_dma(1'b1, 1'b0, 16'h0041, 8'h00);
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         chk1("sat_rdy", cpu_rdy, (i % 12) < 4);
         chk1("sat_gnt", dma_gnt, (i % 12) >= 4);
         advance();
      end
      idle();
      @(negedge clk);
      advance();

      // Stalled CPU keeps its last read data while a forced DMA read returns
      set_dma(1'b1, 1'b0, 16'h0400, 8'h00);
      for (int i = 0; i < 7; i++) begin
         set_cpu(1'b1, 1'b1, (i >= 3) ? 16'h0010 : 16'h0020, 8'h00);
         if (i == 6) dma_req = 1'b0;
         @(negedge clk);
         if (i == 3) chk1("stall_svc_rdy", cpu_rdy, 1'b1);
         if (i == 4) begin
            chk1("stall_rdy", cpu_rdy, 1'b0);
            chkv("stall_cpu_di0", 16'(cpu_di), 16'h0077);
         end
         if (i == 5) begin
            chkv("stall_cpu_di1", 16'(cpu_di), 16'h0077);
            chk1("stall_rvalid", dma_rvalid, 1'b1);
            chkv("stall_dma_rdata", 16'(dma_rdata), 16'h0011);
         end
         if (i == 6) chk1("stall_release_rdy", cpu_rdy, 1'b1);
         advance();
      end
      idle();
      @(negedge clk);
      advance();

      // DMA drops after 3 forced grants: back to CPU with starvation count cleared
      set_cpu(1'b1, 1'b1, 16'h0050, 8'h00);
      for (int i = 0; i < 13; i++) begin
         set_dma(i != 7, 1'b0, 16'h0051, 8'h00);
         @(negedge clk);
         if (i >= 4 && i <= 6) chk1("drop_gnt", dma_gnt, 1'b1);
         if (i >= 7 && i <= 11) begin
            chk1("drop_rdy", cpu_rdy, 1'b1);
            chk1("drop_nogrant", dma_gnt, 1'b0);
         end
         if (i == 12) chk1("drop_reforced", dma_gnt, 1'b1);
         advance();
      end
      idle();
      @(negedge clk);
      advance();

      // Asynchronous reset in the middle of a forced burst
      set_cpu(1'b1, 1'b0, 16'h0600, 8'hE1);
      set_dma(1'b1, 1'b0, 16'h0601, 8'h00);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         advance();
      end
      #2 reset = 1'b1;
      #1;
      chk1("async_rst_rdy", cpu_rdy, 1'b1);
      chk1("async_rst_gnt", dma_gnt, 1'b0);
      chk1("async_rst_we", ram_we, 1'b0);
      chk1("async_rst_rvalid", dma_rvalid, 1'b0);
      @(negedge clk);
      advance();
      @(negedge clk);
      advance();
      #2 reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk1("post_rst_gnt", dma_gnt, i == 4);
         advance();
      end
      idle();
      @(negedge clk);
      advance();

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 499) == 0);
         if (prev_rdy) begin
            if (((i / 500) % 2) == 1) cpu_sel = ($urandom_range(0, 15) != 0);
            else                      cpu_sel = ($urandom_range(0, 1) != 0);
            cpu_we_n = ($urandom_range(0, 1) != 0);
            cpu_ab   = 16'($urandom_range(0, 63));
            cpu_do   = 8'($urandom);
         end
         if (prev_gnt || !dma_req) begin
            dma_req   = ($urandom_range(0, 2) != 0);
            dma_we    = ($urandom_range(0, 1) != 0);
            dma_addr  = 16'($urandom_range(0, 63));
            dma_wdata = 8'($urandom);
         end else if ($urandom_range(0, 15) == 0) begin
            dma_req = 1'b0;
         end
         @(negedge clk);
         advance();
      end
      reset = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
